// File: rtl/sequence_generator_if.sv
// rtl/sequence_generator_if.sv - Request and serial-stream bundle for sequence_generator
`timescale 1ns/1ps

interface sequence_generator_if #(
  parameter int MAX_LEN = 8,
  parameter int LW      = $clog2(MAX_LEN + 1)
);
  logic               start;
  logic [MAX_LEN-1:0] pattern;
  logic [LW-1:0]      pat_len;
  logic [3:0]         reps;
  logic [2:0]         gap;
  logic               serial_out;
  logic               bit_valid;
  logic               busy;
  logic               done;

  modport master (
    output start, pattern, pat_len, reps, gap,
    input  serial_out, bit_valid, busy, done
  );

  modport slave (
    input  start, pattern, pat_len, reps, gap,
    output serial_out, bit_valid, busy, done
  );
endinterface

// File: rtl/sequence_generator.sv
// rtl/sequence_generator.sv - Repeating MSB-first serial pattern generator with inter-repetition gaps
`timescale 1ns/1ps

module sequence_generator #(
  parameter int MAX_LEN = 8,
  parameter int LW      = $clog2(MAX_LEN + 1)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  sequence_generator_if.slave  bus
);
  localparam int CW = $clog2(MAX_LEN);

  typedef enum logic [1:0] {IDLE, SEND, GAP, FIN} state_t;

  state_t             state, state_nx;
  logic [MAX_LEN-1:0] pat_q, pat_nx;
  logic [LW-1:0]      len_q, len_nx;
  logic [3:0]         rep_q, rep_nx;
  logic [2:0]         gap_q, gap_nx;
  logic [2:0]         gcnt_q, gcnt_nx;
  logic [CW-1:0]      bcnt_q, bcnt_nx;
  logic               sout_q, sout_nx;
  logic               valid_q, valid_nx;
  logic               busy_q, busy_nx;
  logic               done_q, done_nx;

  logic [LW-1:0]      len_in;
  logic [CW-1:0]      msb_in;
  logic [CW-1:0]      msb_q;
  logic [CW-1:0]      bcnt_dec;

  // Oversized lengths are clamped so the bit counter never indexes past the pattern.
  assign len_in   = (bus.pat_len > LW'(MAX_LEN)) ? LW'(MAX_LEN) : bus.pat_len;
  assign msb_in   = CW'(len_in - LW'(1));
  assign msb_q    = CW'(len_q - LW'(1));
  assign bcnt_dec = bcnt_q - CW'(1);

  always_comb begin
    state_nx = state;
    pat_nx   = pat_q;
    len_nx   = len_q;
    rep_nx   = rep_q;
    gap_nx   = gap_q;
    gcnt_nx  = gcnt_q;
    bcnt_nx  = bcnt_q;
    sout_nx  = 1'b0;
    valid_nx = 1'b0;
    busy_nx  = 1'b0;
    done_nx  = 1'b0;

    case (state)
      IDLE: begin
        if (bus.start) begin
          pat_nx = bus.pattern;
          len_nx = len_in;
          rep_nx = (bus.reps == 4'd0) ? 4'd1 : bus.reps;
          gap_nx = bus.gap;
          if (len_in == LW'(0)) begin
            state_nx = FIN;
            done_nx  = 1'b1;
          end else begin
            state_nx = SEND;
            bcnt_nx  = msb_in;
            sout_nx  = bus.pattern[msb_in];
            valid_nx = 1'b1;
            busy_nx  = 1'b1;
          end
        end
      end

      SEND: begin
        if (bcnt_q != CW'(0)) begin
          bcnt_nx  = bcnt_dec;
          sout_nx  = pat_q[bcnt_dec];
          valid_nx = 1'b1;
          busy_nx  = 1'b1;
        end else if (rep_q > 4'd1) begin
          // rep_q counts repetitions still owed including the current one; it stops at 1.
          rep_nx  = rep_q - 4'd1;
          busy_nx = 1'b1;
          if (gap_q != 3'd0) begin
            state_nx = GAP;
            gcnt_nx  = gap_q - 3'd1;
          end else begin
            bcnt_nx  = msb_q;
            sout_nx  = pat_q[msb_q];
            valid_nx = 1'b1;
          end
        end else begin
          state_nx = FIN;
          done_nx  = 1'b1;
        end
      end

      GAP: begin
        busy_nx = 1'b1;
        if (gcnt_q == 3'd0) begin
          state_nx = SEND;
          bcnt_nx  = msb_q;
          sout_nx  = pat_q[msb_q];
          valid_nx = 1'b1;
        end else begin
          gcnt_nx = gcnt_q - 3'd1;
        end
      end

      FIN: begin
        state_nx = IDLE;
      end

      default: begin
        state_nx = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      pat_q   <= '0;
      len_q   <= '0;
      rep_q   <= '0;
      gap_q   <= '0;
      gcnt_q  <= '0;
      bcnt_q  <= '0;
      sout_q  <= 1'b0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state   <= state_nx;
      pat_q   <= pat_nx;
      len_q   <= len_nx;
      rep_q   <= rep_nx;
      gap_q   <= gap_nx;
      gcnt_q  <= gcnt_nx;
      bcnt_q  <= bcnt_nx;
      sout_q  <= sout_nx;
      valid_q <= valid_nx;
      busy_q  <= busy_nx;
      done_q  <= done_nx;
    end
  end

  assign bus.serial_out = sout_q;
  assign bus.bit_valid  = valid_q;
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;

endmodule

// File: tb/tb_sequence_generator.sv
// tb/tb_sequence_generator.sv - Self-checking bench for sequence_generator
`timescale 1ns/1ps

module tb_sequence_generator;
  localparam int MAX_LEN = 8;
  localparam int LW      = $clog2(MAX_LEN + 1);

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  sequence_generator_if #(.MAX_LEN(MAX_LEN), .LW(LW)) bus ();

  sequence_generator #(.MAX_LEN(MAX_LEN), .LW(LW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int vectors     = 0;
  int miscompares = 0;

  // Expected per-cycle outputs packed as {serial_out, bit_valid, busy, done}.
  logic [3:0] exp_q[$];
  logic [3:0] cur = 4'b0000;
  int         m_len;
  int         m_reps;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      exp_q.delete();
      cur = 4'b0000;
    end else if (exp_q.size() > 0) begin
      cur = exp_q.pop_front();
    end else if (cur == 4'b0000 && bus.start) begin
      m_len  = (int'(bus.pat_len) > MAX_LEN) ? MAX_LEN : int'(bus.pat_len);
      m_reps = (bus.reps == 4'd0) ? 1 : int'(bus.reps);
      for (int r = 0; r < m_reps && m_len > 0; r++) begin
        for (int i = m_len - 1; i >= 0; i--) exp_q.push_back({bus.pattern[i], 3'b110});
        if (r < m_reps - 1)
          for (int g = 0; g < int'(bus.gap); g++) exp_q.push_back(4'b0010);
      end
      exp_q.push_back(4'b0001);
      cur = exp_q.pop_front();
    end else begin
      cur = 4'b0000;
    end
  end

  function automatic logic [3:0] outs();
    return {bus.serial_out, bus.bit_valid, bus.busy, bus.done};
  endfunction

  task automatic check(input string name, input int got, input int exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  task automatic run_case(input string name, input logic [7:0] pat, input logic [3:0] len,
                          input logic [3:0] rp, input logic [2:0] gp, input int restart_at,
                          input logic [31:0] exp_bits, input int exp_nbits, input int exp_busy);
    logic [31:0] bits;
    int nbits, busy_cnt, dones, done_cyc;
    bits = '0; nbits = 0; busy_cnt = 0; dones = 0; done_cyc = -1;
    @(negedge clk); #1;
    bus.pattern = pat; bus.pat_len = len; bus.reps = rp; bus.gap = gp; bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    bus.pattern = ~pat; bus.pat_len = 4'd1; bus.reps = 4'd2; bus.gap = 3'd5;
    for (int c = 1; c <= 80; c++) begin
      @(negedge clk);
      if (bus.bit_valid) begin
        bits = {bits[30:0], bus.serial_out};
        nbits++;
      end
      if (bus.busy) busy_cnt++;
      if (bus.done) begin
        dones++;
        if (done_cyc < 0) done_cyc = c;
      end
      #1 bus.start = (c == restart_at);
    end
    bus.start = 1'b0;
    check($sformatf("%s.bits", name), int'(bits), int'(exp_bits));
    check($sformatf("%s.nbits", name), nbits, exp_nbits);
    check($sformatf("%s.busy_cycles", name), busy_cnt, exp_busy);
    check($sformatf("%s.done_count", name), dones, 1);
    check($sformatf("%s.done_cycle", name), done_cyc, exp_busy + 1);
  endtask

  initial begin
    int dones;
    bus.start = 1'b0; bus.pattern = '0; bus.pat_len = '0; bus.reps = '0; bus.gap = '0;

    fork
      forever begin
        @(negedge clk);
        vectors++;
        if (outs() !== cur) begin
          miscompares++;
          $display("FAIL cycle_outputs t=%0t got=%b expected=%b", $time, outs(), cur);
        end
      end
    join_none

    repeat (2) @(negedge clk);
    check("reset_outputs", int'(outs()), 0);

    // Start held across reset release must be taken on the very first edge.
    bus.pattern = 8'h05; bus.pat_len = 4'd3; bus.reps = 4'd1; bus.gap = 3'd0; bus.start = 1'b1;
    rst_n = 1'b1;
    @(negedge clk);
    check("first_edge_accept", int'({bus.serial_out, bus.bit_valid}), 3);
    #1 bus.start = 1'b0;
    repeat (6) @(negedge clk);

    run_case("single_1f",    8'h1F, 4'd5,  4'd1,  3'd0, 0, 32'h0000001F, 5,  5);
    run_case("gap2_1011",    8'h0B, 4'd4,  4'd2,  3'd2, 0, 32'h000000BB, 8,  10);
    run_case("b2b_restart",  8'h02, 4'd2,  4'd3,  3'd0, 3, 32'h0000002A, 6,  6);
    run_case("len_zero",     8'hFF, 4'd0,  4'd3,  3'd1, 0, 32'h00000000, 0,  0);
    run_case("len_clamp",    8'hA5, 4'd15, 4'd1,  3'd0, 0, 32'h000000A5, 8,  8);
    run_case("reps_zero",    8'h06, 4'd3,  4'd0,  3'd3, 0, 32'h00000006, 3,  3);
    run_case("reps_max",     8'h01, 4'd2,  4'd15, 3'd1, 0, 32'h15555555, 30, 44);
    run_case("gap_max",      8'h01, 4'd1,  4'd2,  3'd7, 0, 32'h00000003, 2,  9);

    // Asynchronous reset in the middle of an 8-bit transmission.
    @(negedge clk); #1;
    bus.pattern = 8'hC3; bus.pat_len = 4'd8; bus.reps = 4'd1; bus.gap = 3'd0; bus.start = 1'b1;
    @(posedge clk); #1 bus.start = 1'b0;
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b0;
    #1 check("async_reset_outputs", int'(outs()), 0);
    #1 rst_n = 1'b1;
    dones = 0;
    repeat (12) begin
      @(negedge clk);
      if (bus.done) dones++;
    end
    check("no_done_after_reset", dones, 0);
    run_case("after_reset", 8'hC3, 4'd8, 4'd1, 3'd0, 0, 32'h000000C3, 8, 8);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/sequence_generator.md
SEQUENCE_GENERATOR -- requirements
Module: sequence_generator

Interface
REQ-001 Parameter MAX_LEN, default 8, SHALL set the maximum pattern length in bits (legal 2..16).
REQ-002 Parameter LW, default $clog2(MAX_LEN+1), SHALL set the width of pat_len.
REQ-003 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  SHALL be the asynchronous, active-low reset.
REQ-005 start  input  1  SHALL request a transmission; sampled only while busy=0.
REQ-006 pattern  input  MAX_LEN  SHALL hold the bit pattern, transmitted MSB-first from bit pat_len-1 down to bit 0.
REQ-007 pat_len  input  LW  SHALL give the number of pattern bits per repetition.
REQ-008 reps  input  4  SHALL give the repetition count; 0 is treated as 1.
REQ-009 gap  input  3  SHALL give the number of idle cycles inserted between repetitions.
REQ-010 serial_out  output  1  SHALL carry the serial bit stream; it drives input_sequence of sequence_detector_behavioral/structural.
REQ-011 bit_valid  output  1  SHALL be high exactly in cycles where serial_out carries a pattern bit.
REQ-012 busy  output  1  SHALL be high from the cycle after an accepted start until done.
REQ-013 done  output  1  SHALL pulse high for one cycle when a transmission completes.

Function
REQ-014 The FSM SHALL have states IDLE, SEND, GAP and FIN; all outputs SHALL be registered.
REQ-015 In IDLE with start=1 at a rising edge, the block SHALL capture pattern, pat_len (clamped to MAX_LEN), reps and gap, and enter SEND.
REQ-016 The first bit, pattern[pat_len-1], SHALL appear on serial_out with bit_valid=1 in the cycle after the accepting edge (latency 1).
REQ-017 In SEND, one bit SHALL be emitted per cycle; a bit counter SHALL run from pat_len-1 down to 0.
REQ-018 After bit 0, if repetitions remain and gap>0, the FSM SHALL enter GAP for exactly gap cycles with serial_out=0 and bit_valid=0.
REQ-019 After bit 0, if repetitions remain and gap=0, the next repetition's MSB SHALL follow back-to-back with no idle cycle.
REQ-020 After bit 0 of the last repetition, the FSM SHALL enter FIN for one cycle: done=1, busy=0, bit_valid=0, serial_out=0; it then returns to IDLE.
REQ-021 Total busy cycles SHALL equal reps*pat_len + (reps-1)*gap.
REQ-022 start while busy=1 or in FIN SHALL be ignored, and input changes after capture SHALL NOT affect the transmission.
REQ-023 pat_len=0 SHALL emit no bits: FIN (done pulse) in the cycle after the accepting edge, and busy never asserted.
REQ-024 In IDLE, serial_out, bit_valid, busy and done SHALL all be 0.
REQ-025 The repetition counter SHALL be 4 bits wide and SHALL NOT wrap; the counter values reached are 1..15.

Reset
REQ-026 rst_n=0 SHALL immediately force state IDLE and serial_out=0, bit_valid=0, busy=0, done=0, and clear all counters and captured registers, including mid-transmission.
REQ-027 After rst_n deasserts, the block SHALL accept a start on the first rising edge.

Verification
REQ-028 pattern=8'h1F, pat_len=5, reps=1, gap=0, start one cycle -> serial_out 1,1,1,1,1 with bit_valid=1 for 5 cycles; done pulses on cycle 6; the detector loopback asserts detected.
REQ-029 pattern=4'b1011, pat_len=4, reps=2, gap=2 -> serial_out 1,0,1,1,0,0,1,0,1,1; bit_valid=0 only on cycles 5-6; busy for 10 cycles; then done.
REQ-030 reps=3, gap=0, pattern=2'b10, pat_len=2 -> 1,0,1,0,1,0 contiguous; start re-pulsed mid-stream is ignored; a single done.
REQ-031 rst_n pulsed low during bit 3 of an 8-bit transmission -> all outputs 0 within that cycle; no done; a new start afterward transmits from the MSB.
REQ-032 pat_len=0 -> done one cycle after start, bit_valid never high; pat_len=15 with MAX_LEN=8 -> exactly 8 bits emitted.
